// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_CNT_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/instr_mem_loader_word_packer.sv
// Packs a byte stream big-endian into 32-bit words and keeps a mod-256 byte sum.
module instr_mem_loader_word_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full,
  output logic [7:0]  o_sum
);

  logic [23:0]           r_shift;
  logic [BYTE_CNT_W-1:0] r_cnt;
  logic [7:0]            r_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else if (i_push) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 1'b1;
      r_sum   <= r_sum + i_byte;
    end
  end

  // The word is complete in the same cycle as its fourth byte, so the top can
  // register it straight into the memory write port.
  assign o_word      = {r_shift, i_byte};
  assign o_word_full = i_push && (r_cnt == BYTE_CNT_W'(WORD_BYTES - 1));
  assign o_sum       = r_sum;

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: byte stream -> word writes into instruction memory, checksum-gated CPU release.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] word_count,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cpu_hold
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_n;
  logic [ADDR_WIDTH-1:0] r_index;

  logic                w_xfer;
  logic                w_arm;
  logic                w_push;
  logic                w_last;
  logic [ADDR_WIDTH:0] w_n_req;
  logic [31:0]         w_word;
  logic                w_word_full;
  logic [7:0]          w_sum;

  assign w_xfer  = byte_valid && byte_ready;
  assign w_arm   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_push  = w_xfer && (r_state == ST_RECV);
  assign w_last  = ({1'b0, r_index} == (r_n - ONE));
  assign w_n_req = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

  instr_mem_loader_word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_arm),
    .i_push      (w_push),
    .i_byte      (byte_data),
    .o_word      (w_word),
    .o_word_full (w_word_full),
    .o_sum       (w_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_n        <= '0;
      r_index    <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_n      <= w_n_req;
            r_index  <= '0;
            error    <= 1'b0;
            // An empty load finishes immediately with a clean result.
            if (w_n_req == '0) begin
              r_state  <= ST_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
            end else begin
              r_state    <= ST_RECV;
              done       <= 1'b0;
              busy       <= 1'b1;
              cpu_hold   <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (w_word_full) begin
            r_state    <= ST_WRITE;
            byte_ready <= 1'b0;
            mem_we     <= 1'b1;
            mem_addr   <= 32'({r_index, 2'b00});
            mem_wdata  <= w_word;
          end
        end
        ST_WRITE: begin
          mem_we     <= 1'b0;
          byte_ready <= 1'b1;
          if (w_last) begin
            r_state <= ST_CHECK;
          end else begin
            r_index <= r_index + 1'b1;
            r_state <= ST_RECV;
          end
        end
        ST_CHECK: begin
          if (w_xfer) begin
            r_state    <= ST_DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            error      <= (byte_data != w_sum);
            cpu_hold   <= (byte_data != w_sum);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader with a word/checksum reference model.
module tb_instr_mem_loader;

  localparam int AW = 8;
  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   word_count;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_hold;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        exp_err;

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  // Reference: word i is bytes 4i..4i+3 big-endian at byte address 4i; the
  // checksum must equal the mod-256 sum of all data bytes.
  function automatic int clamp_n(input logic [AW:0] wc);
    return (int'(wc) > 256) ? 256 : int'(wc);
  endfunction

  function automatic void build_model(input byte_q_t b, input int n, input logic [7:0] chk);
    int s;
    s = 0;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(32'(i * 4));
      exp_data_q.push_back({b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]});
      for (int k = 0; k < 4; k++) s += int'(b[4*i+k]);
    end
    exp_err = (n > 0) && (chk != 8'(s % 256));
  endfunction

  function automatic logic [7:0] good_sum(input byte_q_t b, input int n);
    int s;
    s = 0;
    for (int k = 0; k < 4 * n; k++) s += int'(b[k]);
    return 8'(s % 256);
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
    int t;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    if (poke_start) begin
      start      = 1'b1;
      word_count = AW'($urandom);
    end
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL byte_ready_timeout: byte_ready=%0b after %0d cycles, required 1", byte_ready, t);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic do_load(input logic [AW:0] wc, input byte_q_t b, input logic [7:0] chk,
                         input int max_gap, input bit poke);
    int n;
    int t;
    n = clamp_n(wc);
    build_model(b, n, chk);
    word_count = wc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < 4 * n; i++)
      send_byte(b[i], int'($urandom_range(0, max_gap)), poke && (i == 2 || i == 6));
    if (n > 0) send_byte(chk, int'($urandom_range(0, max_gap)), 1'b0);
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, t);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; word_count = '0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cpu_hold, done, byte_ready, mem_we, busy, error} !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_flags: hold/done/rdy/we/busy/err=%b required 100000",
               {cpu_hold, done, byte_ready, mem_we, busy, error});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mem: addr=%h wdata=%h required 0/0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    byte_q_t b;
    b = '{8'h20, 8'h09, 8'h00, 8'h05, 8'h20, 8'h0A, 8'h00, 8'h04};
    do_load(9'd2, b, good_sum(b, 2), 0, 1'b0);
    n_cmp++;
    if (wr_addr_q.size() != exp_addr_q.size()) begin
      n_err++;
      $display("FAIL basic_nwrites: got %0d required %0d", wr_addr_q.size(), exp_addr_q.size());
    end
    foreach (exp_addr_q[i]) if (i < wr_addr_q.size()) begin
      n_cmp++;
      if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
        n_err++;
        $display("FAIL basic_write%0d: got (%h,%h) required (%h,%h)", i,
                 wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
    n_cmp++;
    if ({done, error, cpu_hold, busy} !== {1'b1, exp_err, exp_err, 1'b0}) begin
      n_err++;
      $display("FAIL basic_status: done/err/hold/busy=%b required %b",
               {done, error, cpu_hold, busy}, {1'b1, exp_err, exp_err, 1'b0});
    end
  endtask

  task automatic test_bad_checksum();
    byte_q_t b;
    b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_load(9'd1, b, 8'h00, 1, 1'b0);
    n_cmp++;
    if (wr_addr_q.size() != 1 || wr_data_q[0] !== 32'hDEADBEEF || wr_addr_q[0] !== 32'h0) begin
      n_err++;
      $display("FAIL badsum_write: n=%0d first=(%h,%h) required 1 write (00000000,deadbeef)",
               wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hx,
               (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx);
    end
    n_cmp++;
    if ({done, error, cpu_hold, busy} !== {1'b1, exp_err, exp_err, 1'b0}) begin
      n_err++;
      $display("FAIL badsum_status: done/err/hold/busy=%b required %b",
               {done, error, cpu_hold, busy}, {1'b1, exp_err, exp_err, 1'b0});
    end
  endtask

  task automatic test_gaps_start();
    byte_q_t b;
    for (int k = 0; k < 12; k++) b.push_back(8'($urandom));
    do_load(9'd3, b, good_sum(b, 3), 4, 1'b1);
    n_cmp++;
    if (wr_addr_q.size() != exp_addr_q.size()) begin
      n_err++;
      $display("FAIL gaps_nwrites: got %0d required %0d", wr_addr_q.size(), exp_addr_q.size());
    end
    foreach (exp_addr_q[i]) if (i < wr_addr_q.size()) begin
      n_cmp++;
      if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
        n_err++;
        $display("FAIL gaps_write%0d: got (%h,%h) required (%h,%h)", i,
                 wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
      end
    end
    n_cmp++;
    if ({done, error, cpu_hold, busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL gaps_status: done/err/hold/busy=%b required 1000", {done, error, cpu_hold, busy});
    end
  endtask

  task automatic test_zero_words();
    byte_q_t b;
    do_load(9'd0, b, 8'h00, 0, 1'b0);
    n_cmp++;
    if (wr_addr_q.size() != 0 || {done, error, cpu_hold, busy} !== 4'b1000) begin
      n_err++;
      $display("FAIL zero_load: nwrites=%0d done/err/hold/busy=%b required 0 and 1000",
               wr_addr_q.size(), {done, error, cpu_hold, busy});
    end
  endtask

  task automatic test_clamp();
    byte_q_t b;
    int bad;
    for (int k = 0; k < 1024; k++) b.push_back(8'($urandom));
    do_load(9'h1FF, b, good_sum(b, 256), 0, 1'b0);
    n_cmp++;
    if (wr_addr_q.size() != 256) begin
      n_err++;
      $display("FAIL clamp_nwrites: got %0d required 256", wr_addr_q.size());
    end
    bad = 0;
    foreach (exp_addr_q[i]) if (i < wr_addr_q.size())
      if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL clamp_writes: %0d words wrong, required 0", bad);
    end
    n_cmp++;
    if (wr_addr_q.size() == 0 || wr_addr_q[$] !== 32'h3FC) begin
      n_err++;
      $display("FAIL clamp_last_addr: got %h required 000003fc",
               (wr_addr_q.size() > 0) ? wr_addr_q[$] : 32'hx);
    end
    n_cmp++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      n_err++;
      $display("FAIL clamp_status: done/err/hold=%b required 100", {done, error, cpu_hold});
    end
  endtask

  task automatic test_reset_midload();
    byte_q_t b;
    int seen_rdy;
    for (int k = 0; k < 8; k++) b.push_back(8'($urandom));
    build_model(b, 2, 8'h00);
    word_count = 9'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < 6; i++) send_byte(b[i], 0, 1'b0);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({cpu_hold, done, byte_ready, mem_we, busy, error} !== 6'b100000 ||
        {mem_addr, mem_wdata} !== 64'h0) begin
      n_err++;
      $display("FAIL midreset_state: hold/done/rdy/we/busy/err=%b addr=%h wdata=%h required 100000 0 0",
               {cpu_hold, done, byte_ready, mem_we, busy, error}, mem_addr, mem_wdata);
    end
    n_cmp++;
    if (wr_addr_q.size() != 1 || wr_data_q[0] !== exp_data_q[0]) begin
      n_err++;
      $display("FAIL midreset_word0: nwrites=%0d required 1 of %h", wr_addr_q.size(), exp_data_q[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    byte_valid = 1'b1;
    seen_rdy = 0;
    for (int c = 0; c < 8; c++) begin
      byte_data = 8'($urandom);
      @(negedge clk);
      if (byte_ready) seen_rdy++;
    end
    byte_valid = 1'b0;
    n_cmp++;
    if (wr_addr_q.size() != 1 || seen_rdy != 0) begin
      n_err++;
      $display("FAIL midreset_idle: nwrites=%0d ready_cycles=%0d required 1 and 0", wr_addr_q.size(), seen_rdy);
    end
    b.delete();
    for (int k = 0; k < 4; k++) b.push_back(8'($urandom));
    do_load(9'd1, b, good_sum(b, 1), 2, 1'b0);
    n_cmp++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== exp_data_q[0] ||
        {done, error, cpu_hold} !== 3'b100) begin
      n_err++;
      $display("FAIL midreset_reload: nwrites=%0d done/err/hold=%b required 1 write of %h and 100",
               wr_addr_q.size(), {done, error, cpu_hold}, exp_data_q[0]);
    end
  endtask

  task automatic test_random();
    byte_q_t b;
    logic [7:0] chk;
    int n;
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 6));
      b.delete();
      for (int k = 0; k < 4 * n; k++) b.push_back(8'($urandom));
      chk = $urandom_range(0, 1) ? good_sum(b, n) : 8'($urandom);
      do_load(AW'(n), b, chk, 3, 1'b0);
      n_cmp++;
      if (wr_addr_q.size() != exp_addr_q.size()) begin
        n_err++;
        $display("FAIL rand%0d_nwrites: got %0d required %0d", r, wr_addr_q.size(), exp_addr_q.size());
      end
      foreach (exp_addr_q[i]) if (i < wr_addr_q.size()) begin
        n_cmp++;
        if (wr_addr_q[i] !== exp_addr_q[i] || wr_data_q[i] !== exp_data_q[i]) begin
          n_err++;
          $display("FAIL rand%0d_write%0d: got (%h,%h) required (%h,%h)", r, i,
                   wr_addr_q[i], wr_data_q[i], exp_addr_q[i], exp_data_q[i]);
        end
      end
      n_cmp++;
      if ({done, error, cpu_hold, busy} !== {1'b1, exp_err, exp_err, 1'b0}) begin
        n_err++;
        $display("FAIL rand%0d_status: done/err/hold/busy=%b required %b", r,
                 {done, error, cpu_hold, busy}, {1'b1, exp_err, exp_err, 1'b0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_gaps_start();
    test_zero_words();
    test_clamp();
    test_reset_midload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
